spi_frame_rx: RTL

SPI_FRAME_RX -- requirements
Module: spi_frame_rx

---
 rtl/spi_frame_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_frame_rx.sv
// spi_frame_rx
//   SPI slave frame receiver. Samples i_mosi on i_sclk rising edges while
//   i_csb is low, assembles a 24-bit frame (16 payload bits + CRC-8), checks
//   the CRC and publishes the payload fields. In daisy-chain mode (MODE=1)
//   the received bits are forwarded on o_miso, 24 SCLK cycles late.
//
// Parameters
//   MODE        0 = single slave (o_miso tied low), 1 = daisy-chain
//   FRAME_BITS  bits per frame (only 24 is supported)
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset
//   i_sclk     SPI clock (asynchronous), sampled on its rising edge
//   i_csb      SPI chip select (asynchronous), active low
//   i_mosi     SPI data in (asynchronous), MSB first
//   o_miso     SPI data out (daisy-chain forwarding)
//   o_vld      one-cycle pulse: good frame, data outputs updated
//   o_rw       payload bit 15
//   o_addr     payload bits 14:8
//   o_wdata    payload bits 7:0
//   o_crc_err  one-cycle pulse: CRC mismatch
//   o_len_err  one-cycle pulse: CSB released mid-frame
//   o_frm_cnt  good-frame counter, wraps at 256
module spi_frame_rx #(
  parameter int MODE       = 0,
  parameter int FRAME_BITS = 24
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_csb,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_vld,
  output logic       o_rw,
  output logic [6:0] o_addr,
  output logic [7:0] o_wdata,
  output logic       o_crc_err,
  output logic       o_len_err,
  output logic [7:0] o_frm_cnt
);

  localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] LAST_CNT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] PAY_CNT  = 5'(FRAME_BITS - 8);

  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

  state_t                  state, state_nxt;
  logic                    sclk_p0, sclk_p1, sclk_p2;
  logic                    csb_p0, csb_p1, csb_p2;
  logic                    mosi_p0, mosi_p1;
  logic                    sclk_rise, sclk_fall, csb_rise, last_edge;
  logic [FRAME_BITS-1:0]   shift;
  logic [4:0]              bit_cnt;
  logic [7:0]              crc;
  logic                    crc_ok;
  logic                    miso_q;
  logic                    take_bit, clr_frame, do_check, len_abort;

  // One MSB-first step of CRC-8, polynomial x^8+x^2+x+1.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ({8{c[7] ^ b}} & 8'h07);
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: edge-detect history.
  // CSB flops idle high so reset release never looks like a CSB edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      csb_p0  <= 1'b1;
      csb_p1  <= 1'b1;
      csb_p2  <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= i_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      csb_p0  <= i_csb;
      csb_p1  <= csb_p0;
      csb_p2  <= csb_p1;
      mosi_p0 <= i_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign csb_rise  = csb_p1 & ~csb_p2;
  // The edge that completes a frame wins over a simultaneous CSB release.
  assign last_edge = sclk_rise && (bit_cnt == LAST_CNT);
  assign crc_ok    = (shift[7:0] == crc);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_bit  = 1'b0;
    clr_frame = 1'b0;
    do_check  = 1'b0;
    len_abort = 1'b0;
    case (state)
      IDLE: begin
        clr_frame = 1'b1;
        if (!csb_p1) state_nxt = RX;
      end
      RX: begin
        if (bit_cnt == FULL_CNT) begin
          state_nxt = CHECK;
        end else if (csb_rise && !last_edge) begin
          state_nxt = IDLE;
          len_abort = (bit_cnt != 5'd0);
        end else if (sclk_rise) begin
          take_bit = 1'b1;
        end
      end
      CHECK: begin
        do_check  = 1'b1;
        clr_frame = 1'b1;
        state_nxt = csb_p1 ? IDLE : RX;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame assembly: shift register, bit counter and running CRC.
  // The shift register is not cleared between frames so daisy-chain
  // forwarding carries the previous frame out while the next shifts in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift   <= '0;
      bit_cnt <= 5'd0;
      crc     <= 8'h00;
    end else if (clr_frame) begin
      bit_cnt <= 5'd0;
      crc     <= 8'h00;
    end else if (take_bit) begin
      shift   <= {shift[FRAME_BITS-2:0], mosi_p1};
      bit_cnt <= bit_cnt + 5'd1;
      if (bit_cnt < PAY_CNT) crc <= crc8_step(crc, mosi_p1);
    end
  end

  // Result stage: status pulses, payload fields, counter and MISO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld     <= 1'b0;
      o_crc_err <= 1'b0;
      o_len_err <= 1'b0;
      o_rw      <= 1'b0;
      o_addr    <= 7'd0;
      o_wdata   <= 8'd0;
      o_frm_cnt <= 8'd0;
      miso_q    <= 1'b0;
    end else begin
      o_vld     <= do_check && crc_ok;
      o_crc_err <= do_check && !crc_ok;
      o_len_err <= len_abort;
      if (do_check && crc_ok) begin
        {o_rw, o_addr, o_wdata} <= shift[FRAME_BITS-1:8];
        o_frm_cnt               <= o_frm_cnt + 8'd1;
      end
      if (csb_p1)         miso_q <= 1'b0;
      else if (sclk_fall) miso_q <= shift[FRAME_BITS-1];
    end
  end

  assign o_miso = (MODE == 1) ? miso_q : 1'b0;

endmodule
